input_event_queue: RTL and testbench
====================================

# input_event_queue

Converts the eight one-cycle debounced tick pulses (four pad switches, four board buttons) into a stream of 3-bit event codes, buffered in a small FIFO. The game/control logic drains the FIFO through a valid/ready handshake. The block sits directly downstream of the debouncer stage, in the `pclk` domain. No tick is lost to simultaneous arrival or to a stalled consumer, up to FIFO capacity.

## Interface
- `DEPTH`, 8, FIFO depth in entries; power of two, at least 2.
- `pclk  in  1`  pixel/system clock; all logic is on the rising edge.
- `rst  in  1`  asynchronous, active-high reset.
- `pad_Sd, pad_Rd, pad_Ld, pad_Dd  in  1 each`  pad tick pulses, one cycle wide.
- `bttn_Ud, bttn_Dd, bttn_Ld, bttn_Rd  in  1 each`  board tick pulses, one cycle wide.
- `evt_valid  out  1`  FIFO head holds an event.
- `evt_code  out  3`  head event code; meaningful only while `evt_valid` is high.
- `evt_ready  in  1`  consumer accepts the head when high together with `evt_valid`.
- `evt_count  out  $clog2(DEPTH)+1`  number of entries in the FIFO.
- `overflow  out  1`  sticky flag: at least one tick was dropped.

## Operation
- **Source index and code:**
  - 0 = `pad_Sd`, 1 = `pad_Rd`, 2 = `pad_Ld`, 3 = `pad_Dd`
  - 4 = `bttn_Ud`, 5 = `bttn_Dd`, 6 = `bttn_Ld`, 7 = `bttn_Rd`
  - The emitted code equals the source index.
- **Pending register (`pending[7:0]`):**
  - A tick sets its bit.
  - A bit is cleared when that source is granted into the FIFO.
- **Grant in the same cycle as a new tick on that source:** the bit stays set. The new tick becomes a fresh pending event.
- **Tick while the bit is already set and not being granted:** the tick is coalesced (lost) and `overflow` sets.
- **Arbiter:**
  - Each cycle, if `pending != 0` and the FIFO is not full, the lowest-index pending source is pushed and its bit cleared.
  - At most one push per cycle. Fixed priority.
- **FIFO:**
  - Show-ahead: `evt_code` is the head entry, and `evt_valid = (evt_count != 0)`.
  - Pop occurs when `evt_valid && evt_ready`.
- **Full:**
  - Full is `evt_count == DEPTH`, taken from the registered count.
  - No push occurs when full, even with a simultaneous pop. Events wait in `pending`.
- **Empty:** `evt_ready` is ignored and the pointers do not move.
- **Pointer wrap:** read and write pointers wrap modulo `DEPTH`.
- **Count update:**
  - Simultaneous push and pop: count is unchanged.
  - Push only: count +1. Pop only: count −1.

## Timing
- **Reset values:**
  - `pending = 0`, pointers 0, `evt_count = 0`.
  - `evt_valid = 0`, `evt_code = 0`, `overflow = 0`.
- **Reset asserted mid-operation:** all stored events and `pending` are discarded immediately (asynchronous).
- **Latency:**
  - A tick in cycle N sets `pending` at the edge ending N.
  - The push occurs at the edge ending N+1.
  - `evt_valid` is high in cycle N+2.
- **Several simultaneous ticks:** pushed in index order, one per cycle, on consecutive cycles.
- **Pop timing:** a pop at the edge ending cycle M presents the next entry in cycle M+1.
- **`overflow`:** set at the edge following the dropping tick; cleared only by `rst`.

## Configuration
- **`INPUT_MERGE_EN` defined:**
  - Board ticks are ORed into the pad pending bits of the same direction: `bttn_Ud`→0, `bttn_Rd`→1, `bttn_Ld`→2, `bttn_Dd`→3.
  - Codes 4–7 are never produced.
  - A pad tick and its merged board tick in the same cycle count as one event, with no overflow.
- **`INPUT_MERGE_EN` undefined:** all eight sources are distinct, as described above.

## Structure
- **Package `input_event_pkg`:**
  - Code localparams `EVT_PAD_S` … `EVT_BTTN_R` (values 0–7).
  - `EVT_W = 3`.
  - Default `DEPTH`.
- **Sub-module `event_fifo`:**
  - Parameterised show-ahead synchronous FIFO with push/pop, full and count.
  - Owned and instantiated once by `input_event_queue`.
  - Contains the pending register and arbiter only at the top level.

## Test plan
- **Single tick:** `pad_Ld` pulse in cycle 0 -> `evt_valid = 1`, `evt_code = 2` in cycle 2; `evt_ready = 1` -> `evt_count` returns to 0 in cycle 3.
- **Simultaneous ticks:** `pad_Sd`, `bttn_Ud`, `bttn_Rd` all in the same cycle -> codes 0, 4, 7 pushed on three consecutive cycles; popped in that order.
- **Fill:** `evt_ready = 0` and 9 distinct ticks with `DEPTH = 8` -> `evt_count = 8`, 9th held in `pending`. One pop -> 9th pushed the next cycle. `overflow` stays 0.
- **Drop:** `evt_ready = 0`, FIFO full, `pad_Dd` ticked twice -> `overflow = 1` and remains 1 after the FIFO drains.
- **Reset mid-stream:** `rst` pulse with 5 entries queued -> `evt_count = 0`, `evt_valid = 0` and `overflow = 0` immediately.
- **Merge:** with `INPUT_MERGE_EN`, `bttn_Rd` + `pad_Rd` in the same cycle -> exactly one event, code 1.

Source files
------------

// File: rtl/input_event_pkg.sv
// rtl/input_event_pkg.sv - event codes, widths and arbiter helper for input_event_queue
package input_event_pkg;

  localparam int EVT_W         = 3;
  localparam int NUM_SRC       = 8;
  localparam int DEPTH_DEFAULT = 8;

  localparam logic [EVT_W-1:0] EVT_PAD_S  = 3'd0;
  localparam logic [EVT_W-1:0] EVT_PAD_R  = 3'd1;
  localparam logic [EVT_W-1:0] EVT_PAD_L  = 3'd2;
  localparam logic [EVT_W-1:0] EVT_PAD_D  = 3'd3;
  localparam logic [EVT_W-1:0] EVT_BTTN_U = 3'd4;
  localparam logic [EVT_W-1:0] EVT_BTTN_D = 3'd5;
  localparam logic [EVT_W-1:0] EVT_BTTN_L = 3'd6;
  localparam logic [EVT_W-1:0] EVT_BTTN_R = 3'd7;

  // Index of the lowest set bit; 0 when nothing is set (caller qualifies with |v).
  function automatic logic [EVT_W-1:0] lowest_index(input logic [NUM_SRC-1:0] v);
    logic [EVT_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = EVT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - show-ahead synchronous FIFO with push/pop, full flag and occupancy count
module event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;
  assign count_o = count_q;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // Storage array: written only on an accepted push, no reset needed since reads are masked.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push/pop balance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/input_event_queue.sv
// rtl/input_event_queue.sv - tick pulses to 3-bit event codes via pending register, fixed-priority arbiter and FIFO; INPUT_MERGE_EN folds board ticks onto pad codes
module input_event_queue
  import input_event_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    pad_Sd,
  input  logic                    pad_Rd,
  input  logic                    pad_Ld,
  input  logic                    pad_Dd,
  input  logic                    bttn_Ud,
  input  logic                    bttn_Dd,
  input  logic                    bttn_Ld,
  input  logic                    bttn_Rd,
  output logic                    evt_valid,
  output logic [EVT_W-1:0]        evt_code,
  input  logic                    evt_ready,
  output logic [$clog2(DEPTH):0]  evt_count,
  output logic                    overflow
);

  logic [NUM_SRC-1:0] tick_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] grant;
  logic [EVT_W-1:0]   push_code;
  logic               push;
  logic               fifo_full;
  logic               overflow_q, overflow_d;

  // Map the eight tick inputs onto pending-bit positions.
  always_comb begin
    tick_d = '0;
`ifdef INPUT_MERGE_EN
    tick_d[EVT_PAD_S] = pad_Sd | bttn_Ud;
    tick_d[EVT_PAD_R] = pad_Rd | bttn_Rd;
    tick_d[EVT_PAD_L] = pad_Ld | bttn_Ld;
    tick_d[EVT_PAD_D] = pad_Dd | bttn_Dd;
`else
    tick_d[EVT_PAD_S]  = pad_Sd;
    tick_d[EVT_PAD_R]  = pad_Rd;
    tick_d[EVT_PAD_L]  = pad_Ld;
    tick_d[EVT_PAD_D]  = pad_Dd;
    tick_d[EVT_BTTN_U] = bttn_Ud;
    tick_d[EVT_BTTN_D] = bttn_Dd;
    tick_d[EVT_BTTN_L] = bttn_Ld;
    tick_d[EVT_BTTN_R] = bttn_Rd;
`endif
  end

  // Fixed-priority grant of the lowest pending source when the FIFO has room.
  always_comb begin
    grant     = '0;
    push      = 1'b0;
    push_code = lowest_index(pending_q);
    if ((pending_q != '0) && !fifo_full) begin
      push             = 1'b1;
      grant[push_code] = 1'b1;
    end
  end

  // A tick on a granted source re-arms it; a tick on a still-waiting source is coalesced.
  always_comb begin
    pending_d  = (pending_q & ~grant) | tick_d;
    overflow_d = overflow_q | (|(tick_d & pending_q & ~grant));
  end

  // Pending bits and sticky overflow flag.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  event_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk         (pclk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_code),
    .pop_i       (evt_ready),
    .valid_o     (evt_valid),
    .data_o      (evt_code),
    .full_o      (fifo_full),
    .count_o     (evt_count)
  );

endmodule

// File: tb/tb_input_event_queue.sv
// tb/tb_input_event_queue.sv - scoreboard bench for input_event_queue against a queue-based reference model
module tb_input_event_queue;

  localparam int DEPTH = 8;

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic       pad_Sd = 0, pad_Rd = 0, pad_Ld = 0, pad_Dd = 0;
  logic       bttn_Ud = 0, bttn_Dd = 0, bttn_Ld = 0, bttn_Rd = 0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [3:0] evt_count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  input_event_queue #(.DEPTH(DEPTH)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .pad_Sd    (pad_Sd),
    .pad_Rd    (pad_Rd),
    .pad_Ld    (pad_Ld),
    .pad_Dd    (pad_Dd),
    .bttn_Ud   (bttn_Ud),
    .bttn_Dd   (bttn_Dd),
    .bttn_Ld   (bttn_Ld),
    .bttn_Rd   (bttn_Rd),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pending events as a bit per destination, FIFO as a queue.
  int mq[$];
  int exp_q[$];
  bit mpend[8];
  bit movf;
  bit mfull;
  int mg;
  bit mt[8];
`ifdef INPUT_MERGE_EN
  int dest[8] = '{0, 1, 2, 3, 0, 3, 2, 1};
`else
  int dest[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  always @(posedge pclk) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      for (int i = 0; i < 8; i++) mpend[i] = 0;
      movf = 0;
    end else begin
      for (int i = 0; i < 8; i++) mt[i] = 0;
      mt[dest[0]] |= pad_Sd;  mt[dest[1]] |= pad_Rd;
      mt[dest[2]] |= pad_Ld;  mt[dest[3]] |= pad_Dd;
      mt[dest[4]] |= bttn_Ud; mt[dest[5]] |= bttn_Dd;
      mt[dest[6]] |= bttn_Ld; mt[dest[7]] |= bttn_Rd;
      mfull = (mq.size() == DEPTH);
      mg = -1;
      if (!mfull)
        for (int i = 0; i < 8; i++)
          if (mpend[i] && mg < 0) mg = i;
      if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
      if (mg >= 0) begin
        mq.push_back(mg);
        exp_q.push_back(mg);
        mpend[mg] = 0;
      end
      for (int i = 0; i < 8; i++)
        if (mt[i]) begin
          if (mpend[i]) movf = 1;
          mpend[i] = 1;
        end
    end
  end

  // Monitor: compares occupancy/flags every cycle and popped codes at each handshake.
  always @(negedge pclk) begin
    if (!rst) begin
      check("count", 32'(evt_count), 32'(mq.size()));
      check("valid", 32'(evt_valid), 32'(mq.size() != 0));
      check("overflow", 32'(overflow), 32'(movf));
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 32'(evt_code), 32'hFFFF_FFFF);
        else check("pop_code", 32'(evt_code), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #2;
  endtask

  task automatic set_ticks(input logic [7:0] t);
    pad_Sd  = t[0]; pad_Rd  = t[1]; pad_Ld  = t[2]; pad_Dd  = t[3];
    bttn_Ud = t[4]; bttn_Dd = t[5]; bttn_Ld = t[6]; bttn_Rd = t[7];
  endtask

  task automatic idle(input int n);
    set_ticks(8'h00);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1;
    check("rst_count", 32'(evt_count), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_code", 32'(evt_code), 0);
    check("rst_overflow", 32'(overflow), 0);
    step(); step();
    rst = 1'b0;
    step();

    // Single tick: pad_Ld in cycle 0, visible in cycle 2, drained by cycle 3.
    evt_ready = 1'b1;
    set_ticks(8'b0000_0100);
    step();
    set_ticks(8'h00);
    check("single_c1_valid", 32'(evt_valid), 0);
    step();
    check("single_c2_valid", 32'(evt_valid), 1);
    check("single_c2_code", 32'(evt_code), 2);
    step();
    check("single_c3_count", 32'(evt_count), 0);
    idle(2);

    // Simultaneous ticks: pad_Sd, bttn_Ud, bttn_Rd together, held while stalled.
    evt_ready = 1'b0;
    set_ticks(8'b1001_0001);
    step();
    idle(4);
`ifdef INPUT_MERGE_EN
    check("simul_count", 32'(evt_count), 2);
    check("simul_head", 32'(evt_code), 0);
`else
    check("simul_count", 32'(evt_count), 3);
    check("simul_head", 32'(evt_code), 0);
`endif
    evt_ready = 1'b1;
    idle(6);

    // Fill: nine ticks across cycles with the consumer stalled.
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_ticks(8'(1 << i));
      step();
    end
    idle(3);
    check("fill_count", 32'(evt_count), 8);
    set_ticks(8'b0000_0001);
    step();
    idle(3);
    check("fill_held_count", 32'(evt_count), 8);
    check("fill_overflow", 32'(overflow), 0);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("fill_after_pop", 32'(evt_count), 7);
    step();
    check("fill_refill", 32'(evt_count), 8);

    // Drop: pad_Dd twice while full.
    set_ticks(8'b0000_1000);
    step();
    idle(1);
    check("drop_pre_overflow", 32'(overflow), 0);
    set_ticks(8'b0000_1000);
    step();
    set_ticks(8'h00);
    check("drop_overflow", 32'(overflow), 1);
    evt_ready = 1'b1;
    idle(14);
    check("drop_drained", 32'(evt_count), 0);
    check("drop_sticky", 32'(overflow), 1);

    // Reset mid-stream with entries queued.
    evt_ready = 1'b0;
    set_ticks(8'b0001_1111);
    step();
    idle(7);
`ifdef INPUT_MERGE_EN
    check("rstmid_pre_count", 32'(evt_count), 4);
`else
    check("rstmid_pre_count", 32'(evt_count), 5);
`endif
    rst = 1'b1;
    #1;
    check("rstmid_count", 32'(evt_count), 0);
    check("rstmid_valid", 32'(evt_valid), 0);
    check("rstmid_overflow", 32'(overflow), 0);
    step();
    rst = 1'b0;
    step();

    // Merge pair: pad_Rd with bttn_Rd in one cycle.
    evt_ready = 1'b0;
    set_ticks(8'b1000_0010);
    step();
    idle(4);
`ifdef INPUT_MERGE_EN
    check("merge_count", 32'(evt_count), 1);
    check("merge_code", 32'(evt_code), 1);
`else
    check("merge_count", 32'(evt_count), 2);
    check("merge_code", 32'(evt_code), 1);
`endif
    evt_ready = 1'b1;
    idle(4);

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 2000; c++) begin
      logic [7:0] t;
      for (int b = 0; b < 8; b++) t[b] = ($urandom_range(0, 9) == 0);
      set_ticks(t);
      evt_ready = ($urandom_range(0, 99) < 45);
      step();
    end
    evt_ready = 1'b1;
    idle(30);
    check("final_scoreboard_empty", 32'(exp_q.size()), 0);
    check("final_count", 32'(evt_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
